// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Serial program loader; shifts bytes in over a 2-wire link,
//               writes them to the instruction memory, verifies an XOR checksum.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int IMEM_SZ     = 16,
    parameter int INST_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic                       ser_clk,
    input  logic                       ser_data,
    output logic                       wr_en,
    output logic [$clog2(IMEM_SZ)-1:0] wr_addr,
    output logic [INST_W-1:0]          wr_data,
    output logic                       core_hold,
    output logic                       core_rst_req,
    output logic                       busy,
    output logic                       done,
    output logic                       csum_err
);

    localparam int AW  = $clog2(IMEM_SZ);
    localparam int BCW = $clog2(IMEM_SZ + 1);
    localparam int BW  = $clog2(INST_W);

    localparam logic [BCW-1:0] c_sz       = BCW'(IMEM_SZ);
    localparam logic [BW-1:0]  c_bit_last = BW'(INST_W - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_shift = 3'd1;
    localparam logic [2:0] c_st_write = 3'd2;
    localparam logic [2:0] c_st_check = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [SYNC_STAGES-1:0] r_ld_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdat_sync;
    logic                   r_sclk_prev;
    logic [INST_W-1:0]      r_shift;
    logic [BW-1:0]          r_bit_cnt;
    logic [BCW-1:0]         r_byte_cnt;
    logic [INST_W-1:0]      r_csum;
    logic                   r_wr_en;
    logic [AW-1:0]          r_wr_addr;
    logic [INST_W-1:0]      r_wr_data;
    logic                   r_rst_req;
    logic                   r_done;
    logic                   r_csum_err;

    logic                   w_ld_s;
    logic                   w_sclk_s;
    logic                   w_sdat_s;
    logic                   w_rise;
    logic                   w_loading;
    logic                   w_byte_end;
    logic [INST_W-1:0]      w_byte;

    assign w_ld_s     = r_ld_sync[SYNC_STAGES-1];
    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdat_s   = r_sdat_sync[SYNC_STAGES-1];
    assign w_rise     = w_sclk_s & ~r_sclk_prev;
    assign w_loading  = (r_state == c_st_shift) || (r_state == c_st_write);
    assign w_byte_end = w_rise && (r_bit_cnt == c_bit_last);
    // Byte as it will look once the current bit lands.
    assign w_byte     = {r_shift[INST_W-2:0], w_sdat_s};

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_ld_s) w_next = c_st_shift;
            c_st_shift: begin
                if (!w_ld_s)
                    w_next = c_st_idle;
                else if (w_byte_end)
                    w_next = (r_byte_cnt < c_sz) ? c_st_write : c_st_check;
            end
            c_st_write: w_next = w_ld_s ? c_st_shift : c_st_idle;
            c_st_check: w_next = c_st_done;
            c_st_done:  if (!w_ld_s) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy      = (r_state == c_st_shift) || (r_state == c_st_write) ||
                    (r_state == c_st_check);
        core_hold = busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_sync   <= '0;
            r_sclk_sync <= '0;
            r_sdat_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_csum      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rst_req   <= 1'b0;
            r_done      <= 1'b0;
            r_csum_err  <= 1'b0;
        end else begin
            r_ld_sync   <= {r_ld_sync[SYNC_STAGES-2:0], ld_en};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ser_clk};
            r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], ser_data};
            r_sclk_prev <= w_sclk_s;

            if (r_state == c_st_idle && w_next == c_st_shift) begin
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
                r_csum     <= '0;
                r_done     <= 1'b0;
                r_csum_err <= 1'b0;
            end

            if (w_rise && w_loading) begin
                r_shift   <= w_byte;
                r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
            end

            // r_shift still holds the completed byte throughout WRITE.
            if (r_state == c_st_write) begin
                r_csum     <= r_csum ^ r_shift;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (r_state == c_st_check) begin
                r_csum_err <= (r_shift != r_csum);
                r_done     <= 1'b1;
            end

            if (w_loading && !w_ld_s) begin
                r_csum_err <= 1'b1;
                r_done     <= 1'b0;
            end

            r_wr_en   <= (w_next == c_st_write);
            r_wr_addr <= (w_next == c_st_write) ? r_byte_cnt[AW-1:0] : '0;
            r_wr_data <= (w_next == c_st_write) ? w_byte : '0;
            r_rst_req <= (w_next == c_st_check) && (w_byte == r_csum);
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign core_rst_req = r_rst_req;
    assign done         = r_done;
    assign csum_err     = r_csum_err;

endmodule

`default_nettype wire
